// File: rtl/alu_unit_if.sv
// alu_unit_if: operand bus, function select, handshake and flag signals of the registered ALU.
// The tri-stated result bus AUJ3 is a plain port of alu_unit so it can resolve on a shared net.
interface alu_unit_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] D;
  logic             LDDR1;
  logic             LDDR2;
  logic             S3;
  logic             S2;
  logic             S1;
  logic             S0;
  logic             M;
  logic             Cn;
  logic             MUL;
  logic             start;
  logic             ALU_B;
  logic             CY;
  logic             Z;
  logic             busy;
  logic             done;

  modport master (
    output D, LDDR1, LDDR2, S3, S2, S1, S0, M, Cn, MUL, start, ALU_B,
    input  CY, Z, busy, done
  );

  modport slave (
    input  D, LDDR1, LDDR2, S3, S2, S1, S0, M, Cn, MUL, start, ALU_B,
    output CY, Z, busy, done
  );
endinterface

// File: rtl/alu_unit.sv
// alu_unit: registered 74181-style ALU with DR1/DR2 operands, result/CY/Z registers and tri-state bus.
// Define ALU_MUL_EN to add a WIDTH-iteration unsigned shift-add multiplier (MULT state, busy).
module alu_unit #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  alu_unit_if.slave       bus,
  output wire [WIDTH-1:0] AUJ3
);

  logic [WIDTH-1:0] r_dr1;
  logic [WIDTH-1:0] r_dr2;
  logic [WIDTH-1:0] r_res;
  logic             r_cy;
  logic             r_z;
  logic             r_done;
  logic [3:0]       w_f;
  logic [WIDTH:0]   w_alu;
  logic             w_busy;
  logic             w_single_go;

  // Returns {carry, result}; logic mode always reports carry 0.
  function automatic logic [WIDTH:0] alu_eval(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [3:0]       f,
    input logic             m,
    input logic             cn
  );
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] ones;
    ones = '1;
    x    = '0;
    y    = '0;
    r    = '0;
    if (m) begin
      case (f)
        4'd0:    r = ~a;
        4'd1:    r = ~(a | b);
        4'd2:    r = ~a & b;
        4'd3:    r = '0;
        4'd4:    r = ~(a & b);
        4'd5:    r = ~b;
        4'd6:    r = a ^ b;
        4'd7:    r = a & ~b;
        4'd8:    r = ~a | b;
        4'd9:    r = ~(a ^ b);
        4'd10:   r = b;
        4'd11:   r = a & b;
        4'd12:   r = ones;
        4'd13:   r = a | ~b;
        4'd14:   r = a | b;
        default: r = a;
      endcase
      alu_eval = {1'b0, r};
    end else begin
      case (f)
        4'd0:    begin x = a;        y = '0;     end
        4'd1:    begin x = a | b;    y = '0;     end
        4'd2:    begin x = a | ~b;   y = '0;     end
        4'd3:    begin x = '0;       y = ones;   end
        4'd4:    begin x = a;        y = a & ~b; end
        4'd5:    begin x = a | b;    y = a & ~b; end
        4'd6:    begin x = a;        y = ~b;     end
        4'd7:    begin x = a & ~b;   y = ones;   end
        4'd8:    begin x = a;        y = a & b;  end
        4'd9:    begin x = a;        y = b;      end
        4'd10:   begin x = a | ~b;   y = a & b;  end
        4'd11:   begin x = a & b;    y = ones;   end
        4'd12:   begin x = a;        y = a;      end
        4'd13:   begin x = a | b;    y = a;      end
        4'd14:   begin x = a | ~b;   y = a;      end
        default: begin x = a;        y = ones;   end
      endcase
      alu_eval = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cn};
    end
  endfunction

  assign w_f   = {bus.S3, bus.S2, bus.S1, bus.S0};
  assign w_alu = alu_eval(r_dr1, r_dr2, w_f, bus.M, ~bus.Cn);

`ifdef ALU_MUL_EN
  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [0:0]      ST_IDLE  = 1'b0;
  localparam logic [0:0]      ST_MULT  = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [0:0]         r_state;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic               w_mul_go;
  logic               w_mul_last;

  assign w_busy      = (r_state == ST_MULT);
  assign w_mul_go    = bus.start & bus.MUL & ~w_busy;
  assign w_single_go = bus.start & ~bus.MUL & ~w_busy;
  assign w_mul_last  = w_busy & (r_cnt == CNT_LAST);
  assign w_acc_nxt   = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  // Private operand copies: DR loads during MULT leave the product in flight untouched.
  always_ff @(posedge clk) begin
    if (w_mul_go) begin
      r_mcand  <= {{WIDTH{1'b0}}, r_dr1};
      r_mplier <= r_dr2;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_busy) begin
      r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
      r_acc    <= w_acc_nxt;
      r_cnt    <= r_cnt + 1'b1;
    end
  end
`else
  logic w_unused;

  assign w_busy      = 1'b0;
  assign w_single_go = bus.start;
  assign w_unused    = bus.MUL;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dr1   <= '0;
      r_dr2   <= '0;
      r_res   <= '0;
      r_cy    <= 1'b0;
      r_z     <= 1'b0;
      r_done  <= 1'b0;
`ifdef ALU_MUL_EN
      r_state <= ST_IDLE;
`endif
    end else begin
      r_done <= 1'b0;
      if (bus.LDDR1) r_dr1 <= bus.D;
      if (bus.LDDR2) r_dr2 <= bus.D;
      if (w_single_go) begin
        r_res  <= w_alu[WIDTH-1:0];
        r_cy   <= w_alu[WIDTH];
        r_z    <= ~|w_alu[WIDTH-1:0];
        r_done <= 1'b1;
      end
`ifdef ALU_MUL_EN
      else if (w_mul_go) begin
        r_state <= ST_MULT;
      end else if (w_mul_last) begin
        r_res   <= w_acc_nxt[WIDTH-1:0];
        r_cy    <= |w_acc_nxt[2*WIDTH-1:WIDTH];
        r_z     <= ~|w_acc_nxt[WIDTH-1:0];
        r_done  <= 1'b1;
        r_state <= ST_IDLE;
      end
`endif
    end
  end

  assign bus.CY   = r_cy;
  assign bus.Z    = r_z;
  assign bus.busy = w_busy;
  assign bus.done = r_done;
  assign AUJ3     = bus.ALU_B ? {WIDTH{1'bz}} : r_res;

endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed vectors with hand-computed results for alu_unit (WIDTH=8).
// Expected multiply results switch with ALU_MUL_EN; without it MUL=1 falls back to the selected ALU op.
module tb_alu_unit;

`ifdef ALU_MUL_EN
  localparam int         MUL_EN  = 1;
  localparam int         MUL_LAT = 8;
  localparam logic [7:0] R1 = 8'hFF;  // 0x0F * 0x11
  localparam logic       C1 = 1'b0;
  localparam logic [7:0] R2 = 8'h00;  // 0x10 * 0x10
  localparam logic       C2 = 1'b1;
  localparam logic       Z2 = 1'b1;
  localparam logic [7:0] R3 = 8'h0F;  // 0x03 * 0x05
`else
  localparam int         MUL_EN  = 0;
  localparam int         MUL_LAT = 0;
  localparam logic [7:0] R1 = 8'h20;  // 0x0F + 0x11
  localparam logic       C1 = 1'b0;
  localparam logic [7:0] R2 = 8'h20;  // 0x10 + 0x10
  localparam logic       C2 = 1'b0;
  localparam logic       Z2 = 1'b0;
  localparam logic [7:0] R3 = 8'h08;  // 0x03 + 0x05
`endif

  logic       clk;
  logic       rst;
  wire  [7:0] auj3;
  int         n_chk;
  int         n_fail;
  int         n;
  int         n_done;

  alu_unit_if #(.WIDTH(8)) bus ();

  alu_unit #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .AUJ3 (auj3)
  );

  // A released bus reads back as zero.
  for (genvar g = 0; g < 8; g++) begin : g_pd
    pulldown (auj3[g]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required summary");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] b);
    bus.D = a; bus.LDDR1 = 1'b1; bus.LDDR2 = 1'b0;
    tick();
    bus.D = b; bus.LDDR1 = 1'b0; bus.LDDR2 = 1'b1;
    tick();
    bus.LDDR2 = 1'b0;
  endtask

  task automatic op(input logic [3:0] f, input logic m, input logic cn, input logic mul);
    {bus.S3, bus.S2, bus.S1, bus.S0} = f;
    bus.M = m; bus.Cn = cn; bus.MUL = mul; bus.start = 1'b1;
    tick();
    bus.start = 1'b0; bus.MUL = 1'b0; bus.LDDR1 = 1'b0; bus.LDDR2 = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic [7:0] r, input logic cy, input logic z);
    chk({tag, "_res"}, {24'd0, auj3}, {24'd0, r});
    chk({tag, "_cy"}, {31'd0, bus.CY}, {31'd0, cy});
    chk({tag, "_z"}, {31'd0, bus.Z}, {31'd0, z});
  endtask

  // Counts edges after the start edge until done, bounded at 20.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!bus.done && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1;
    bus.D = '0; bus.LDDR1 = 1'b0; bus.LDDR2 = 1'b0;
    {bus.S3, bus.S2, bus.S1, bus.S0} = 4'd0;
    bus.M = 1'b0; bus.Cn = 1'b1; bus.MUL = 1'b0; bus.start = 1'b0; bus.ALU_B = 1'b0;
    tick(); tick();
    rst = 1'b0;

    chk_res("rst", 8'h00, 1'b0, 1'b0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);

    load(8'h5A, 8'hA5);
    op(4'd9, 1'b0, 1'b1, 1'b0);
    chk_res("add_nc", 8'hFF, 1'b0, 1'b0);
    chk("add_nc_done", {31'd0, bus.done}, 32'd1);
    tick();
    chk("add_nc_done_pulse", {31'd0, bus.done}, 32'd0);
    bus.ALU_B = 1'b1;
    #1;
    chk("alub_hiz", {24'd0, auj3}, 32'h00);
    bus.ALU_B = 1'b0;
    #1;
    chk("alub_drive", {24'd0, auj3}, 32'hFF);

    op(4'd9, 1'b0, 1'b0, 1'b0);
    chk_res("add_c", 8'h00, 1'b1, 1'b1);

    load(8'h10, 8'h10);
    op(4'd6, 1'b0, 1'b0, 1'b0);
    chk_res("sub", 8'h00, 1'b1, 1'b1);
    op(4'd6, 1'b1, 1'b0, 1'b0);
    chk_res("xor", 8'h00, 1'b0, 1'b1);

    load(8'h01, 8'h00);
    bus.D = 8'h33; bus.LDDR1 = 1'b1;
    op(4'd15, 1'b1, 1'b1, 1'b0);
    chk_res("ld_same", 8'h01, 1'b0, 1'b0);
    op(4'd15, 1'b1, 1'b1, 1'b0);
    chk_res("ld_next", 8'h33, 1'b0, 1'b0);

    load(8'hFF, 8'h00);
    op(4'd0, 1'b0, 1'b0, 1'b0);
    chk_res("inc_wrap", 8'h00, 1'b1, 1'b1);
    op(4'd3, 1'b0, 1'b1, 1'b0);
    chk_res("minus1", 8'hFF, 1'b0, 1'b0);
    op(4'd0, 1'b1, 1'b1, 1'b0);
    chk_res("not_a", 8'h00, 1'b0, 1'b1);
    load(8'h80, 8'h00);
    op(4'd12, 1'b0, 1'b1, 1'b0);
    chk_res("dbl", 8'h00, 1'b1, 1'b1);
    load(8'h0F, 8'hF0);
    op(4'd1, 1'b1, 1'b1, 1'b0);
    chk_res("nor", 8'h00, 1'b0, 1'b1);
    op(4'd2, 1'b1, 1'b1, 1'b0);
    chk_res("nota_and_b", 8'hF0, 1'b0, 1'b0);
    op(4'd7, 1'b0, 1'b1, 1'b0);
    chk_res("andnb_m1", 8'h0E, 1'b1, 1'b0);

    // Multiply request; a load and a start arrive mid-operation.
    load(8'h0F, 8'h11);
    op(4'd9, 1'b0, 1'b1, 1'b1);
    chk("mul1_busy", {31'd0, bus.busy}, MUL_EN[31:0]);
    chk("mul1_hold", {24'd0, auj3}, (MUL_EN != 0) ? 32'h0E : {24'd0, R1});
    n = 0;
    while (!bus.done && n < 20) begin
      if (n == 2) begin bus.D = 8'hAA; bus.LDDR1 = 1'b1; end
      if (n == 3) begin
        {bus.S3, bus.S2, bus.S1, bus.S0} = 4'd15;
        bus.M = 1'b1; bus.start = 1'b1;
      end
      tick();
      bus.start = 1'b0; bus.LDDR1 = 1'b0; bus.M = 1'b0;
      n++;
    end
    chk("mul1_lat", n, MUL_LAT);
    chk_res("mul1", R1, C1, 1'b0);
    chk("mul1_busy_end", {31'd0, bus.busy}, 32'd0);
    tick();
    chk("mul1_no_requeue", {31'd0, bus.done}, 32'd0);
    chk("mul1_res_kept", {24'd0, auj3}, {24'd0, R1});

    load(8'h10, 8'h10);
    op(4'd9, 1'b0, 1'b1, 1'b1);
    wait_done(n);
    chk("mul2_lat", n, MUL_LAT);
    chk_res("mul2", R2, C2, Z2);

    // Reset three cycles after a multiply request.
    load(8'h0F, 8'h11);
    op(4'd9, 1'b0, 1'b1, 1'b1);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_res("abort", 8'h00, 1'b0, 1'b0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done) n_done++;
    end
    chk("abort_no_done", n_done, 0);
    load(8'h03, 8'h05);
    op(4'd9, 1'b0, 1'b1, 1'b1);
    wait_done(n);
    chk("post_rst_lat", n, MUL_LAT);
    chk_res("post_rst", R3, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
